board_controller: RTL

- Game-state engine directly upstream of the VGA controller.
- Turns button presses into board contents (seven 12-bit column words), the cursor column A and the current player colour; the VGA stage consumes these for display.
- Owns the turn sequencing, gravity drop, full-column rejection and end-of-game detection.

---
 rtl/board_pkg.sv | 28 ++
 rtl/board_controller_win_checker.sv | 58 +++++
 rtl/board_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the board game engine: cell codes, board geometry, FSM states, helpers.
package board_pkg;

  localparam int unsigned NUM_COLS = 7;
  localparam int unsigned NUM_ROWS = 6;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P0    = 2'b01;
  localparam logic [1:0] CELL_P1    = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t PLAY  = 2'd0;
  localparam state_t DROP  = 2'd1;
  localparam state_t CHECK = 2'd2;
  localparam state_t OVER  = 2'd3;

  // Element 0 is the leftmost column; cell r of a column sits at bits [2r+1:2r].
  typedef logic [NUM_COLS-1:0][2*NUM_ROWS-1:0] board_t;

  function automatic logic [3:0] cell_off(input logic [2:0] row);
    return {row, 1'b0};
  endfunction

  function automatic logic [1:0] player_code(input logic player);
    return player ? CELL_P1 : CELL_P0;
  endfunction

endpackage

// File: rtl/board_controller_win_checker.sv
// Combinational four-in-a-line detector through the most recently placed cell.
module win_checker
  import board_pkg::*;
(
  input  board_t     board,
  input  logic [2:0] last_col,
  input  logic [2:0] last_row,
  input  logic       player,
  output logic       win
);

  // Off-board positions read as empty so runs stop at the edges.
  function automatic logic [1:0] cell_at(input board_t b, input int c, input int r);
    logic [2:0] ci;
    logic [2:0] ri;
    if (c < 0 || c >= int'(NUM_COLS) || r < 0 || r >= int'(NUM_ROWS)) return CELL_EMPTY;
    ci = c[2:0];
    ri = r[2:0];
    return b[ci][cell_off(ri) +: 2];
  endfunction

  logic [1:0] code;
  int         lc;
  int         lr;
  int         dc;
  int         dr;
  int         run;
  logic       go_p;
  logic       go_n;

  always_comb begin
    win  = 1'b0;
    code = player_code(player);
    lc   = int'(last_col);
    lr   = int'(last_row);
    dc   = 0;
    dr   = 0;
    run  = 0;
    go_p = 1'b0;
    go_n = 1'b0;
    // Directions: horizontal, vertical, rising diagonal, falling diagonal.
    for (int d = 0; d < 4; d++) begin
      dc   = (d == 1) ? 0 : 1;
      dr   = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
      run  = 0;
      go_p = 1'b1;
      go_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        if (go_p && cell_at(board, lc + dc * k, lr + dr * k) == code) run = run + 1;
        else go_p = 1'b0;
        if (go_n && cell_at(board, lc - dc * k, lr - dr * k) == code) run = run + 1;
        else go_n = 1'b0;
      end
      if (run >= 3) win = 1'b1;
    end
  end

endmodule

// File: rtl/board_controller.sv
// Game-state engine feeding the VGA stage: cursor, turns, gravity drop, end-of-game.
// Define WIN_DETECT_EN to add four-in-a-line win detection; otherwise games end as draws.
module board_controller
  import board_pkg::*;
#(
  parameter int unsigned START_COL    = 3,
  parameter logic        FIRST_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_drop,
  output logic [2:0]  A,
  output logic        player_colour,
  output logic [11:0] col1,
  output logic [11:0] col2,
  output logic [11:0] col3,
  output logic [11:0] col4,
  output logic [11:0] col5,
  output logic [11:0] col6,
  output logic [11:0] col7,
  output logic        game_over,
  output logic [1:0]  winner
);

  logic       btn_left_q, btn_right_q, btn_drop_q;
  logic       ev_left, ev_right, ev_drop;
  state_t     state_q, state_d;
  board_t     board_q, board_d;
  logic [2:0] a_q, a_d;
  logic       player_q, player_d;
  logic       over_q, over_d;
  logic [1:0] winner_q, winner_d;
  logic [2:0] free_row;
  logic       col_full;
  logic       board_full;
  logic       win;

  assign ev_left  = btn_left & ~btn_left_q;
  assign ev_right = btn_right & ~btn_right_q;
  assign ev_drop  = btn_drop & ~btn_drop_q;

`ifdef WIN_DETECT_EN
  logic [2:0] row_q, row_d;

  win_checker u_win_checker (
    .board    (board_q),
    .last_col (a_q),
    .last_row (row_q),
    .player   (player_q),
    .win      (win)
  );
`else
  assign win = 1'b0;
`endif

  // Gravity keeps columns packed from the bottom, so the lowest empty cell is the target.
  always_comb begin
    free_row = 3'd0;
    for (int r = int'(NUM_ROWS) - 1; r >= 0; r--) begin
      if (board_q[a_q][cell_off(3'(r)) +: 2] == CELL_EMPTY) free_row = 3'(r);
    end
  end

  assign col_full = board_q[a_q][11:10] != CELL_EMPTY;

  always_comb begin
    board_full = 1'b1;
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      if (board_q[c][11:10] == CELL_EMPTY) board_full = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    a_d      = a_q;
    player_d = player_q;
    over_d   = over_q;
    winner_d = winner_q;
`ifdef WIN_DETECT_EN
    row_d    = row_q;
`endif
    case (state_q)
      PLAY: begin
        if (ev_drop) begin
          if (!col_full) state_d = DROP;
        end else if (ev_left && !ev_right) begin
          if (a_q != 3'd0) a_d = a_q - 3'd1;
        end else if (ev_right && !ev_left) begin
          if (a_q != 3'(NUM_COLS - 1)) a_d = a_q + 3'd1;
        end
      end
      DROP: begin
        board_d[a_q][cell_off(free_row) +: 2] = player_code(player_q);
`ifdef WIN_DETECT_EN
        row_d = free_row;
`endif
        state_d = CHECK;
      end
      CHECK: begin
        if (win) begin
          over_d   = 1'b1;
          winner_d = player_code(player_q);
          state_d  = OVER;
        end else if (board_full) begin
          over_d   = 1'b1;
          winner_d = CELL_EMPTY;
          state_d  = OVER;
        end else begin
          player_d = ~player_q;
          state_d  = PLAY;
        end
      end
      OVER: begin
        if (ev_drop) begin
          board_d  = '0;
          a_d      = 3'(START_COL);
          player_d = FIRST_PLAYER;
          over_d   = 1'b0;
          winner_d = CELL_EMPTY;
          state_d  = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_left_q  <= 1'b0;
      btn_right_q <= 1'b0;
      btn_drop_q  <= 1'b0;
      state_q     <= PLAY;
      board_q     <= '0;
      a_q         <= 3'(START_COL);
      player_q    <= FIRST_PLAYER;
      over_q      <= 1'b0;
      winner_q    <= CELL_EMPTY;
`ifdef WIN_DETECT_EN
      row_q       <= 3'd0;
`endif
    end else begin
      btn_left_q  <= btn_left;
      btn_right_q <= btn_right;
      btn_drop_q  <= btn_drop;
      state_q     <= state_d;
      board_q     <= board_d;
      a_q         <= a_d;
      player_q    <= player_d;
      over_q      <= over_d;
      winner_q    <= winner_d;
`ifdef WIN_DETECT_EN
      row_q       <= row_d;
`endif
    end
  end

  assign A             = a_q;
  assign player_colour = player_q;
  assign game_over     = over_q;
  assign winner        = winner_q;
  assign col1          = board_q[0];
  assign col2          = board_q[1];
  assign col3          = board_q[2];
  assign col4          = board_q[3];
  assign col5          = board_q[4];
  assign col6          = board_q[5];
  assign col7          = board_q[6];

endmodule
